// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous imem reads, stall hold buffer
// and branch/jump redirect with a registered IF/ID flush.
module fetch_unit #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   flush
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic                   issue;
    logic                   capture;

    always_comb begin
        issue      = !rst && !redirect_valid && !stall;
        // Stalled with read data arriving: park it so it is not lost.
        capture    = !rst && !redirect_valid && stall && (state == RUN);
        state_next = state;
        if (redirect_valid) begin
            state_next = IDLE;
        end else if (issue) begin
            state_next = RUN;
        end else if (capture) begin
            state_next = HOLD;
        end

        imem_req  = issue;
        imem_addr = pc;

        out_valid = 1'b0;
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    out_valid = 1'b1;
                    out_instr = imem_rdata;
                    out_pc    = fetch_pc + PC_WIDTH'(1);
                end
                HOLD: begin
                    out_valid = 1'b1;
                    out_instr = hold_instr;
                    out_pc    = hold_pc;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            fetch_pc   <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            flush      <= 1'b0;
        end else begin
            flush <= redirect_valid;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= pc;
                pc       <= pc + PC_WIDTH'(1);
            end
            if (capture) begin
                hold_instr <= imem_rdata;
                hold_pc    <= fetch_pc + PC_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synchronous memory model plus a
// delivery-order reference model of what IF/ID should observe.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        flush;

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .flush(flush)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    // Read data appears one cycle after the strobe; junk otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        else imem_rdata <= $urandom;
    end

    int total = 0;
    int bad = 0;

    // Model: m_avail = an instruction is presented to IF/ID,
    // m_deliv = address IF/ID must see next, m_req = next address to read.
    logic       m_avail;
    logic [7:0] m_deliv;
    logic [7:0] m_req;
    logic       m_flush;

    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    logic        e_flush;

    task automatic set_in(input logic r, input logic s, input logic rv,
                          input logic [7:0] rp);
        rst = r;
        stall = s;
        redirect_valid = rv;
        redirect_pc = rp;
        #1;
        if (r) begin
            e_req = 1'b0;
            e_valid = 1'b0;
            e_instr = 32'h0;
            e_pc = 8'h0;
        end else begin
            e_req = !rv && !s;
            e_valid = m_avail;
            e_instr = m_avail ? mem[m_deliv] : 32'h0;
            e_pc = m_avail ? m_deliv + 8'd1 : 8'd0;
        end
        e_addr = m_req;
        e_flush = m_flush;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        if (rst) begin
            m_avail = 1'b0;
            m_deliv = 8'h0;
            m_req = 8'h0;
            m_flush = 1'b0;
        end else begin
            m_flush = redirect_valid;
            if (redirect_valid) begin
                m_avail = 1'b0;
                m_deliv = redirect_pc;
                m_req = redirect_pc;
            end else if (!stall) begin
                if (m_avail) m_deliv = m_deliv + 8'd1;
                m_req = m_req + 8'd1;
                m_avail = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(i < 2, 1'b0, 1'b0, 8'h0);
            total++;
            if (imem_req !== e_req) begin
                bad++;
                $display("FAIL reset[%0d] req act=%b exp=%b", i, imem_req, e_req);
            end
            if (e_req) begin
                total++;
                if (imem_addr !== e_addr) begin
                    bad++;
                    $display("FAIL reset[%0d] addr act=%h exp=%h", i, imem_addr, e_addr);
                end
            end
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL reset[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            next_cyc();
        end
    endtask

    task automatic test_stream();
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 8'h0);
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL stream[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            total++;
            if (imem_req !== e_req || imem_addr !== e_addr) begin
                bad++;
                $display("FAIL stream[%0d] req act=%b/%h exp=%b/%h", i,
                         imem_req, imem_addr, e_req, e_addr);
            end
            next_cyc();
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b0, (i >= 3 && i <= 5), 1'b0, 8'h0);
            total++;
            if (imem_req !== e_req) begin
                bad++;
                $display("FAIL stall[%0d] req act=%b exp=%b", i, imem_req, e_req);
            end
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL stall[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            next_cyc();
        end
    endtask

    task automatic test_redirect();
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b0, 1'b0, (i == 4), 8'h40);
            total++;
            if (flush !== e_flush) begin
                bad++;
                $display("FAIL redirect[%0d] flush act=%b exp=%b", i, flush, e_flush);
            end
            total++;
            if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin
                bad++;
                $display("FAIL redirect[%0d] req act=%b/%h exp=%b/%h", i,
                         imem_req, imem_addr, e_req, e_addr);
            end
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL redirect[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            next_cyc();
        end
    endtask

    task automatic test_redirect_hold();
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b0, (i >= 3 && i <= 5), (i == 4), 8'h80);
            total++;
            if (flush !== e_flush) begin
                bad++;
                $display("FAIL redir_hold[%0d] flush act=%b exp=%b", i, flush, e_flush);
            end
            total++;
            if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin
                bad++;
                $display("FAIL redir_hold[%0d] req act=%b/%h exp=%b/%h", i,
                         imem_req, imem_addr, e_req, e_addr);
            end
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL redir_hold[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            next_cyc();
        end
    endtask

    task automatic test_wrap();
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, (i == 2), 8'hFE);
            total++;
            if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin
                bad++;
                $display("FAIL wrap[%0d] req act=%b/%h exp=%b/%h", i,
                         imem_req, imem_addr, e_req, e_addr);
            end
            total++;
            if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc) begin
                bad++;
                $display("FAIL wrap[%0d] out act=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_instr, out_pc, e_valid, e_instr, e_pc);
            end
            next_cyc();
        end
    endtask

    task automatic test_random();
        logic r;
        logic s;
        logic rv;
        logic [7:0] rp;
        set_in(1'b1, 1'b0, 1'b0, 8'h0);
        next_cyc();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 35);
            rv = ($urandom_range(0, 99) < 8);
            rp = 8'($urandom);
            set_in(r, s, rv, rp);
            total++;
            if (imem_req !== e_req) begin
                bad++;
                $display("FAIL random[%0d] req act=%b exp=%b", i, imem_req, e_req);
            end
            if (e_req) begin
                total++;
                if (imem_addr !== e_addr) begin
                    bad++;
                    $display("FAIL random[%0d] addr act=%h exp=%h", i, imem_addr, e_addr);
                end
            end
            total++;
            if (out_valid !== e_valid) begin
                bad++;
                $display("FAIL random[%0d] valid act=%b exp=%b", i, out_valid, e_valid);
            end
            total++;
            if (out_instr !== e_instr) begin
                bad++;
                $display("FAIL random[%0d] instr act=%h exp=%h", i, out_instr, e_instr);
            end
            total++;
            if (out_pc !== e_pc) begin
                bad++;
                $display("FAIL random[%0d] pc act=%h exp=%h", i, out_pc, e_pc);
            end
            total++;
            if (flush !== e_flush) begin
                bad++;
                $display("FAIL random[%0d] flush act=%b exp=%b", i, flush, e_flush);
            end
            next_cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        m_avail = 1'b0;
        m_deliv = 8'h0;
        m_req = 8'h0;
        m_flush = 1'b0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h0;
        @(negedge clk);
        next_cyc();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
